// File: rtl/cadence_gen.sv
// Pedal-cadence square-wave generator: programmable half-period, speed ramps,
// finite bursts, start/stop control and a saturating rising-edge counter.
module cadence_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] half_per,
  input  logic [CNT_W-1:0] half_per_lim,
  input  logic [CNT_W-1:0] step,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             cadence,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] cur_half_per
);
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;
  localparam logic [1:0] M_CONST = 2'b00, M_UP = 2'b01, M_DOWN = 2'b10, M_BURST = 2'b11;

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_phase, w_phase_nx;
  logic [CNT_W-1:0] r_cur, w_cur_nx;
  logic [NUM_W-1:0] r_rise, w_rise_nx;
  logic             r_done, w_done_nx;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_lim, r_step;
  logic [NUM_W-1:0] r_num;
  logic             w_cfg_ld;

  logic [CNT_W-1:0] w_phase_inc, w_floor, w_ramp;
  logic [CNT_W:0]   w_sum;
  logic             w_phase_end;

  assign w_phase_inc = r_phase + 1'b1;
  assign w_phase_end = (w_phase_inc == r_cur);
  assign w_floor     = (r_lim == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : r_lim;
  // Extra bit keeps the ramp-down sum from wrapping before the ceiling clamp.
  assign w_sum       = {1'b0, r_cur} + {1'b0, r_step};

  always_comb begin
    w_ramp = r_cur;
    case (r_mode)
      M_UP: begin
        if (r_cur <= w_floor)              w_ramp = r_cur;
        else if (r_cur - w_floor <= r_step) w_ramp = w_floor;
        else                               w_ramp = r_cur - r_step;
      end
      M_DOWN: begin
        if (r_cur >= r_lim)               w_ramp = r_cur;
        else if (w_sum > {1'b0, r_lim})   w_ramp = r_lim;
        else                              w_ramp = w_sum[CNT_W-1:0];
      end
      default: w_ramp = r_cur;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_cur   <= '0;
      r_rise  <= '0;
      r_done  <= 1'b0;
      r_mode  <= M_CONST;
      r_lim   <= '0;
      r_step  <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_cur   <= w_cur_nx;
      r_rise  <= w_rise_nx;
      r_done  <= w_done_nx;
      if (w_cfg_ld) begin
        r_mode <= mode;
        r_lim  <= half_per_lim;
        r_step <= step;
        r_num  <= num_pulses;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_cur_nx   = r_cur;
    w_rise_nx  = r_rise;
    w_done_nx  = 1'b0;
    w_cfg_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_cfg_ld = 1'b1;
          if (mode == M_BURST && num_pulses == '0) begin
            w_done_nx = 1'b1;
            w_rise_nx = '0;
          end else begin
            w_state_nx = S_HIGH;
            w_phase_nx = '0;
            w_cur_nx   = (half_per == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : half_per;
            w_rise_nx  = {{(NUM_W-1){1'b0}}, 1'b1};
          end
        end
      end
      S_HIGH: begin
        if (stop) begin
          w_state_nx = S_IDLE;
          w_phase_nx = '0;
        end else if (w_phase_end) begin
          w_state_nx = S_LOW;
          w_phase_nx = '0;
        end else begin
          w_phase_nx = w_phase_inc;
        end
      end
      S_LOW: begin
        if (stop) begin
          w_state_nx = S_IDLE;
          w_phase_nx = '0;
        end else if (w_phase_end) begin
          w_phase_nx = '0;
          if (r_mode == M_BURST && r_rise == r_num) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = S_HIGH;
            w_cur_nx   = w_ramp;
            w_rise_nx  = (&r_rise) ? r_rise : r_rise + 1'b1;
          end
        end else begin
          w_phase_nx = w_phase_inc;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_phase_nx = '0;
      end
    endcase
  end

  // Outputs decode registered state only
  always_comb begin
    cadence      = (r_state == S_HIGH);
    busy         = (r_state != S_IDLE);
    done         = r_done;
    rise_cnt     = r_rise;
    cur_half_per = r_cur;
  end
endmodule

// File: doc/cadence_gen.md
Name: cadence_gen

Overview:
- Parametrised pedal-cadence stimulus generator for eBike system benches.
- Replaces the fixed 2048-cycle toggle loop. Adds programmable half-period, speed ramps up and down, finite bursts, start/stop control and a rising-edge counter.
- Synthesizable RTL. Drives the DUT `cadence` input directly. Sits beside AnalogModel and eBikePhysics in the top bench.

Parameters:
- CNT_W, 16: width of half-period, limit, step and phase counter.
- NUM_W, 16: width of burst length and rising-edge counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin generation. Ignored while busy.
- stop  in  1  single-cycle abort request.
- mode  in  2  00 CONST, 01 RAMP_UP (half-period shrinks), 10 RAMP_DOWN (half-period grows), 11 BURST.
- half_per  in  CNT_W  initial half-period in clk cycles. 0 is treated as 1.
- half_per_lim  in  CNT_W  ramp end-point. Used by RAMP modes only.
- step  in  CNT_W  ramp increment applied once per full period.
- num_pulses  in  NUM_W  number of rising edges in BURST mode.
- cadence  out  1  generated square wave.
- busy  out  1  high while generating.
- done  out  1  one-cycle pulse when a BURST completes.
- rise_cnt  out  NUM_W  rising edges since last start. Saturates at all-ones.
- cur_half_per  out  CNT_W  half-period currently in use.

Behaviour:
- Reset values: cadence=0, busy=0, done=0, rise_cnt=0, cur_half_per=0, state IDLE, phase counter 0.
- States are IDLE, HIGH, LOW.
- Configuration (mode, half_per, lim, step, num_pulses) is latched in the cycle start is sampled in IDLE. Later input changes have no effect until the next start.

Start (IDLE):
- Cycle after start: rise_cnt cleared, then set to 1.
- cur_half_per = max(half_per, 1), busy=1, cadence=1, state HIGH.
- Exception: BURST with num_pulses=0. Then cadence stays 0, done pulses the next cycle, busy stays 0, rise_cnt=0.

HIGH phase:
- cadence=1 for exactly cur_half_per cycles, then LOW.

LOW phase:
- cadence=0 for exactly cur_half_per cycles.
- Period is 2*cur_half_per cycles, duty 50%.

End of LOW:
- CONST: return to HIGH with the same half-period.
- RAMP_UP: next = cur - step, clamped to a floor of max(lim, 1). No wrap below zero.
- RAMP_DOWN: next = cur + step, clamped to a ceiling of lim. Computed at CNT_W+1 bits so there is no overflow wrap.
- RAMP modes: if lim lies on the wrong side of the start value, the block runs at the start value forever.
- RAMP modes: once lim is reached, the block runs at lim indefinitely.
- New half-period takes effect with the next HIGH phase. Re-enter HIGH and increment rise_cnt (saturating).
- BURST: if rise_cnt == num_pulses, go to IDLE, busy=0, done=1 for one cycle. Otherwise re-enter HIGH.

Stop:
- Sampled in any non-IDLE state, it forces IDLE the next cycle: cadence=0, busy=0, done=0.
- rise_cnt and cur_half_per hold their values for inspection.
- start and stop asserted in the same cycle: stop wins and nothing starts.
- stop in IDLE has no effect.

Reset:
- rst mid-operation returns all outputs to reset values immediately (asynchronous). No done pulse.

General:
- No combinational path from inputs to cadence. All outputs are registered.
- Back-to-back: start in the cycle after done is accepted.

Test Plan:
1. CONST, half_per=2048, start once → cadence rises 1 cycle after start. High 2048 cycles, low 2048 cycles, repeating. rise_cnt=3 after 3*4096 cycles.
2. BURST, half_per=10, num_pulses=3 → exactly 3 high pulses of 10 cycles, 60 cycles total. done pulses once on the cycle busy falls. rise_cnt=3.
3. RAMP_UP, half_per=100, step=30, lim=20 → successive half-periods 100, 70, 40, 20, 20, ...; cur_half_per never below 20.
4. RAMP_DOWN, half_per=CNT max-5, step=10, lim=all-ones → second half-period clamps to all-ones with no wrap.
5. stop asserted mid-HIGH of CONST (half_per=50), plus a second run with start and stop in the same cycle → cadence=0 and busy=0 the next cycle, no done. The same-cycle case never goes busy.
6. Edge cases → half_per=0 yields a 1-cycle high and 1-cycle low toggle. BURST num_pulses=0 gives done with no pulse. rst asserted mid-burst zeroes all outputs asynchronously. start while busy is ignored, with config unchanged.
